// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - round-robin word-to-byte sequencer sharing one byte-wide memory port
// between the fetch and load/store requesters.
module mem_access_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [31:0]       ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic [31:0]       ls_rdata,
    output logic              ls_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [1:0]        k;
    logic              we_q;
    logic              gnt_ls;
    logic              last_ls;
    logic              mem_we_q;
    logic [31:0]       wdata;
    logic [23:0]       asm_lo;

    logic              grant_ls;
    logic [1:0]        k_next;
    logic [ADDR_W-1:0] sel_addr;
    logic              unused_addr_bits;

    // LS wins when alone, or on contention when IF took the previous grant.
    assign grant_ls = ls_req && (!if_req || !last_ls);
    assign sel_addr = grant_ls ? {ls_addr[ADDR_W-1:2], 2'b00} : {if_addr[ADDR_W-1:2], 2'b00};
    assign k_next   = k + 2'd1;

    // Reset kills the write strobe in the same cycle so an interrupted store stops short.
    assign mem_we = mem_we_q & ~rst;

    assign unused_addr_bits = ^{if_addr[31:ADDR_W], if_addr[1:0], ls_addr[31:ADDR_W], ls_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            k         <= 2'd0;
            we_q      <= 1'b0;
            gnt_ls    <= 1'b0;
            last_ls   <= 1'b0;
            mem_we_q  <= 1'b0;
            wdata     <= 32'h0;
            asm_lo    <= 24'h0;
            if_rdata  <= 32'h0;
            ls_rdata  <= 32'h0;
            if_ack    <= 1'b0;
            ls_ack    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || ls_req) begin
                        state     <= XFER;
                        busy      <= 1'b1;
                        gnt_ls    <= grant_ls;
                        base      <= sel_addr;
                        k         <= 2'd0;
                        we_q      <= grant_ls && ls_we;
                        wdata     <= ls_wdata;
                        mem_addr  <= sel_addr;
                        mem_we_q  <= grant_ls && ls_we;
                        mem_wdata <= (grant_ls && ls_we) ? ls_wdata[7:0] : 8'h00;
                    end
                end
                XFER: begin
                    if (!we_q && k != 2'd3) begin
                        asm_lo[8*k +: 8] <= mem_rdata;
                    end
                    k <= k_next;
                    if (k == 2'd3) begin
                        state     <= ACK;
                        mem_addr  <= '0;
                        mem_we_q  <= 1'b0;
                        mem_wdata <= 8'h00;
                        if (gnt_ls) begin
                            ls_ack <= 1'b1;
                        end else begin
                            if_ack <= 1'b1;
                        end
                        // Last byte goes straight from the memory into the result word.
                        if (!we_q) begin
                            if (gnt_ls) begin
                                ls_rdata <= {mem_rdata, asm_lo};
                            end else begin
                                if_rdata <= {mem_rdata, asm_lo};
                            end
                        end
                    end else begin
                        mem_addr  <= base + ADDR_W'(k_next);
                        mem_wdata <= we_q ? wdata[8*k_next +: 8] : 8'h00;
                    end
                end
                ACK: begin
                    if_ack  <= 1'b0;
                    ls_ack  <= 1'b0;
                    last_ls <= gnt_ls;
                    busy    <= 1'b0;
                    k       <= 2'd0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl against a transaction-level model
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = 32'h0;
    logic [31:0] ls_wdata = 32'h0;
    logic [31:0] ls_rdata;
    logic        ls_ack;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        busy;

    logic [7:0]  mem [0:1023];
    logic [7:0]  ref_mem [0:1023];
    logic        ref_last_ls;
    logic [31:0] ref_if_rdata;
    logic [31:0] ref_ls_rdata;

    logic [9:0]  obs_addr [0:14];
    logic        obs_we [0:14];
    logic [7:0]  obs_wd [0:14];
    logic        obs_busy [0:14];

    int passed = 0;
    int total = 0;

    mem_access_ctrl #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rdata(ls_rdata), .ls_ack(ls_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [9:0] b;
        b = {a[9:2], 2'b00};
        return {ref_mem[b + 10'd3], ref_mem[b + 10'd2], ref_mem[b + 10'd1], ref_mem[b]};
    endfunction

    task automatic model_if(input logic [31:0] a);
        ref_if_rdata = ref_word(a);
        ref_last_ls  = 1'b0;
    endtask

    task automatic model_ls(input bit we, input logic [31:0] a, input logic [31:0] wd);
        logic [9:0] b;
        b = {a[9:2], 2'b00};
        if (we) begin
            for (int i = 0; i < 4; i++) ref_mem[b + 10'(i)] = wd[8*i +: 8];
        end else begin
            ref_ls_rdata = ref_word(a);
        end
        ref_last_ls = 1'b1;
    endtask

    task automatic model_reset();
        ref_last_ls  = 1'b0;
        ref_if_rdata = 32'h0;
        ref_ls_rdata = 32'h0;
    endtask

    task automatic run_case(input string name, input bit do_if, input bit do_ls,
                            input logic [31:0] ia, input bit we, input logic [31:0] la,
                            input logic [31:0] wd, output int if_cyc, output int ls_cyc);
        int          exp_if;
        int          exp_ls;
        logic [31:0] exp_if_word;
        logic [31:0] exp_ls_word;
        bit          ls_first;
        exp_if = -1;
        exp_ls = -1;
        if_cyc = -1;
        ls_cyc = -1;
        exp_if_word = ref_if_rdata;
        exp_ls_word = ref_ls_rdata;
        ls_first = do_ls && (!do_if || !ref_last_ls);
        if (ls_first) begin
            exp_ls = 5;
            model_ls(we, la, wd);
            exp_ls_word = ref_ls_rdata;
            if (do_if) begin
                exp_if = 11;
                model_if(ia);
                exp_if_word = ref_if_rdata;
            end
        end else if (do_if) begin
            exp_if = 5;
            model_if(ia);
            exp_if_word = ref_if_rdata;
            if (do_ls) begin
                exp_ls = 11;
                model_ls(we, la, wd);
                exp_ls_word = ref_ls_rdata;
            end
        end
        @(posedge clk); #1;
        if_req = do_if; if_addr = ia;
        ls_req = do_ls; ls_we = we; ls_addr = la; ls_wdata = wd;
        for (int o = 0; o < 15; o++) begin
            @(negedge clk);
            obs_addr[o] = mem_addr; obs_we[o] = mem_we; obs_wd[o] = mem_wdata; obs_busy[o] = busy;
            total++;
            if ({if_ack, ls_ack} !== {o == exp_if, o == exp_ls})
                $display("FAIL %s ack at T+%0d: got if/ls %b%b expected %b%b", name, o,
                         if_ack, ls_ack, o == exp_if, o == exp_ls);
            else passed++;
            if (if_ack === 1'b1) begin
                if_cyc = o; if_req = 1'b0;
                total++;
                if (if_rdata !== exp_if_word)
                    $display("FAIL %s if_rdata: got %h expected %h", name, if_rdata, exp_if_word);
                else passed++;
            end
            if (ls_ack === 1'b1) begin
                ls_cyc = o; ls_req = 1'b0;
                total++;
                if (ls_rdata !== exp_ls_word)
                    $display("FAIL %s ls_rdata: got %h expected %h", name, ls_rdata, exp_ls_word);
                else passed++;
            end
        end
        if_req = 1'b0;
        ls_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({if_rdata, ls_rdata, if_ack, ls_ack, mem_addr, mem_wdata, mem_we} !== 86'h0)
            $display("FAIL reset outputs: got %h %h %b %b %h %h %b expected all zero",
                     if_rdata, ls_rdata, if_ack, ls_ack, mem_addr, mem_wdata, mem_we);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy);
        else passed++;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_store_load();
        int          ic, lc;
        logic [31:0] w;
        w = 32'hA1B2C3D4;
        run_case("store", 1'b0, 1'b1, 32'h0, 1'b1, 32'h10, w, ic, lc);
        for (int c = 1; c <= 4; c++) begin
            total++;
            if ({obs_we[c], obs_addr[c], obs_wd[c]} !== {1'b1, 10'(16 + c - 1), w[8*(c-1) +: 8]})
                $display("FAIL store byte %0d: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                         c - 1, obs_we[c], obs_addr[c], obs_wd[c], 10'(16 + c - 1), w[8*(c-1) +: 8]);
            else passed++;
        end
        total++;
        if ({obs_busy[0], obs_busy[1], obs_busy[2], obs_busy[3], obs_busy[4], obs_busy[5], obs_busy[6]} !== 7'b0111110)
            $display("FAIL store busy window: got %b%b%b%b%b%b%b expected 0111110", obs_busy[0], obs_busy[1],
                     obs_busy[2], obs_busy[3], obs_busy[4], obs_busy[5], obs_busy[6]);
        else passed++;
        total++;
        if ({obs_we[5], obs_addr[5], obs_wd[5]} !== 19'h0)
            $display("FAIL store idle levels in ack: got we=%b addr=%h data=%h expected 0", obs_we[5], obs_addr[5], obs_wd[5]);
        else passed++;
        run_case("load", 1'b0, 1'b1, 32'h0, 1'b0, 32'h12, $urandom, ic, lc);
        total++;
        if ({obs_we[1], obs_we[2], obs_we[3], obs_we[4]} !== 4'b0000)
            $display("FAIL load we: got %b%b%b%b expected 0000", obs_we[1], obs_we[2], obs_we[3], obs_we[4]);
        else passed++;
        total++;
        if (ls_rdata !== w) $display("FAIL load word: got %h expected %h", ls_rdata, w);
        else passed++;
    endtask

    task automatic test_contention();
        int ic, lc;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        model_reset();
        for (int r = 0; r < 2; r++) begin
            run_case("contention", 1'b1, 1'b1, $urandom, 1'(r), $urandom, $urandom, ic, lc);
            total++;
            if (lc !== 5 || ic !== 11)
                $display("FAIL contention %0d order: got ls_ack T+%0d if_ack T+%0d expected T+5 and T+11", r, lc, ic);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        int ic, lc;
        run_case("wrap_top", 1'b1, 1'b0, 32'h7FC, 1'b0, 32'h0, 32'h0, ic, lc);
        total++;
        if ({obs_addr[1], obs_addr[2], obs_addr[3], obs_addr[4]} !== {10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF})
            $display("FAIL wrap_top addrs: got %h %h %h %h expected 3fc 3fd 3fe 3ff",
                     obs_addr[1], obs_addr[2], obs_addr[3], obs_addr[4]);
        else passed++;
        run_case("wrap_zero", 1'b1, 1'b0, 32'h400, 1'b0, 32'h0, 32'h0, ic, lc);
        total++;
        if ({obs_addr[1], obs_addr[2], obs_addr[3], obs_addr[4]} !== {10'h000, 10'h001, 10'h002, 10'h003})
            $display("FAIL wrap_zero addrs: got %h %h %h %h expected 000 001 002 003",
                     obs_addr[1], obs_addr[2], obs_addr[3], obs_addr[4]);
        else passed++;
    endtask

    task automatic test_held_request();
        int          first, second;
        logic        b6;
        logic [31:0] a;
        first = -1; second = -1; b6 = 1'bx;
        a = $urandom;
        model_ls(1'b0, a, 32'h0);
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = a;
        for (int o = 0; o < 18; o++) begin
            @(negedge clk);
            if (o == 6) b6 = busy;
            if (ls_ack === 1'b1) begin
                if (first < 0) first = o;
                else if (second < 0) begin
                    second = o;
                    ls_req = 1'b0;
                end
            end
        end
        ls_req = 1'b0;
        total++;
        if (first !== 5) $display("FAIL held first ack: got T+%0d expected T+5", first);
        else passed++;
        total++;
        if (second - first !== 6) $display("FAIL held ack spacing: got %0d expected 6", second - first);
        else passed++;
        total++;
        if (b6 !== 1'b0) $display("FAIL held idle gap busy: got %b expected 0", b6);
        else passed++;
        total++;
        if (ls_rdata !== ref_ls_rdata) $display("FAIL held ls_rdata: got %h expected %h", ls_rdata, ref_ls_rdata);
        else passed++;
    endtask

    task automatic test_reset_mid_store();
        logic [7:0] old2, old3;
        logic       ack_seen;
        old2 = ref_mem[10'h42];
        old3 = ref_mem[10'h43];
        ack_seen = 1'b0;
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'h11223344;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ls_req = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, mem_we, ls_ack} !== 3'b000)
            $display("FAIL midreset idle: got busy=%b mem_we=%b ls_ack=%b expected 000", busy, mem_we, ls_ack);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            if (ls_ack !== 1'b0) ack_seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (ack_seen !== 1'b0) $display("FAIL midreset ack: got %b expected 0", ack_seen);
        else passed++;
        total++;
        if ({mem[10'h40], mem[10'h41], mem[10'h42], mem[10'h43]} !== {8'h44, 8'h33, old2, old3})
            $display("FAIL midreset bytes: got %h %h %h %h expected 44 33 %h %h",
                     mem[10'h40], mem[10'h41], mem[10'h42], mem[10'h43], old2, old3);
        else passed++;
        ref_mem[10'h40] = 8'h44;
        ref_mem[10'h41] = 8'h33;
        model_reset();
    endtask

    task automatic test_random();
        int ic, lc;
        int pat;
        for (int i = 0; i < 30; i++) begin
            pat = int'($urandom_range(0, 2));
            run_case("random", pat != 1, pat != 0, $urandom, 1'($urandom), $urandom, $urandom, ic, lc);
        end
    endtask

    task automatic test_memory_image();
        int bad;
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        total++;
        if (bad !== 0) $display("FAIL memory image: got %0d differing bytes expected 0", bad);
        else passed++;
    endtask

    initial begin
        logic [7:0] v;
        for (int i = 0; i < 1024; i++) begin
            v = 8'($urandom);
            mem[i] <= v;
            ref_mem[i] = v;
        end
        model_reset();
        test_reset();
        test_store_load();
        test_contention();
        test_wrap();
        test_held_request();
        test_reset_mid_store();
        test_random();
        test_memory_image();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
